// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment patterns and scan-decoder state encoding
// Contents: SEG_0..SEG_F (active-high, bit0=a .. bit6=g) and seg7_state_e.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to hex nibble decoder
// Ports: seg_i [6:0] segment pattern in; hit_o pattern is legal; hex_o [3:0] nibble (0 when not hit).
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] hex_o
);

    always_comb begin
        hit_o = 1'b1;
        hex_o = 4'h0;
        case (seg_i)
            SEG_0:   hex_o = 4'h0;
            SEG_1:   hex_o = 4'h1;
            SEG_2:   hex_o = 4'h2;
            SEG_3:   hex_o = 4'h3;
            SEG_4:   hex_o = 4'h4;
            SEG_5:   hex_o = 4'h5;
            SEG_6:   hex_o = 4'h6;
            SEG_7:   hex_o = 4'h7;
            SEG_8:   hex_o = 4'h8;
            SEG_9:   hex_o = 4'h9;
            SEG_A:   hex_o = 4'hA;
            SEG_B:   hex_o = 4'hB;
            SEG_C:   hex_o = 4'hC;
            SEG_D:   hex_o = 4'hD;
            SEG_E:   hex_o = 4'hE;
            SEG_F:   hex_o = 4'hF;
            default: hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers hex digits from a multiplexed seven-segment display bus
// Ports: clk; reset (sync, active-high); seg [6:0] segment lines; an [N-1:0] one-hot digit enable;
//        hex_out [4N-1:0] recovered nibbles; digit_valid [N-1:0]; frame_valid pulse; err pulse.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // The entry sample already counts as one, so capture fires when the
    // count before this edge is STABLE_CYCLES-1 and the sample still matches.
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

    logic [NUM_DIGITS-1:0]   an_q, an_prev_q;
    logic [6:0]              seg_q, seg_prev_q;
    seg7_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dv_q, dv_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;

    logic                    dec_hit;
    logic [3:0]              dec_hex;
    logic                    sample_changed;
    logic                    an_onehot;
    logic [NUM_DIGITS-1:0]   seen_merged;
    logic                    take_entry;
    logic                    capture;

    seg7_pattern_decode u_decode (
        .seg_i (seg_q),
        .hit_o (dec_hit),
        .hex_o (dec_hex)
    );

    assign sample_changed = (an_q != an_prev_q) || (seg_q != seg_prev_q);
    assign an_onehot      = (an_q != '0) && ((an_q & (an_q - AN_ONE)) == '0);
    assign seen_merged    = seen_q | an_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        hex_d      = hex_q;
        dv_d       = dv_q;
        frame_d    = 1'b0;
        err_d      = 1'b0;
        take_entry = 1'b0;
        capture    = 1'b0;

        case (state_q)
            IDLE: take_entry = 1'b1;
            SETTLE: begin
                if (sample_changed) begin
                    take_entry = 1'b1;
                end else if (cnt_q >= CNT_LAST) begin
                    capture = 1'b1;
                    cnt_d   = CNT_MAX;
                    state_d = CAPTURED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CAPTURED: take_entry = sample_changed;
            default:  state_d = IDLE;
        endcase

        // Shared decision for a fresh sample: blank, start a dwell, or reject.
        if (take_entry) begin
            if (an_q == '0) begin
                state_d = IDLE;
            end else if (an_onehot) begin
                state_d = SETTLE;
                cnt_d   = CNT_ONE;
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end

        // an_q is guaranteed one-hot here: SETTLE is only entered on a one-hot
        // sample and capture requires the sample to be unchanged since then.
        if (capture) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (an_q[k]) begin
                    if (dec_hit) begin
                        hex_d[4*k +: 4] = dec_hex;
                        dv_d[k]         = 1'b1;
                    end else begin
                        dv_d[k] = 1'b0;
                    end
                end
            end
            if (dec_hit) begin
                if (seen_merged == ALL_SEEN) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d = seen_merged;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q       <= '0;
            seg_q      <= '0;
            an_prev_q  <= '0;
            seg_prev_q <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            seen_q     <= '0;
            hex_q      <= '0;
            dv_q       <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            an_q       <= an;
            seg_q      <= seg;
            an_prev_q  <= an_q;
            seg_prev_q <= seg_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            hex_q      <= hex_d;
            dv_q       <= dv_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = dv_q;
    assign frame_valid = frame_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder (4 digits, 3 stable samples)
module tb_seg7_scan_decoder;

    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg = 7'h00;
    logic [3:0]  an = 4'h0;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Reference model: run-length of identical samples decides capture.
    logic [6:0]  seg_tab [16];
    logic [15:0] p_hex, e_hex;
    logic [3:0]  p_dv, e_dv, m_seen;
    logic        p_frame, e_frame, p_err, e_err;
    logic [10:0] m_prev;
    bit          m_have_prev;
    int          m_run;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg),
        .an          (an),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic int decode_ref(input logic [6:0] s);
        for (int i = 0; i < 16; i++)
            if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    task automatic model_sample(input logic [3:0] a, input logic [6:0] s);
        int k;
        int v;
        if (m_have_prev && ({a, s} == m_prev)) m_run++;
        else m_run = 1;
        m_prev = {a, s};
        m_have_prev = 1;
        p_frame = 1'b0;
        p_err = 1'b0;
        if (a == 4'h0) begin
        end else if ($countones(a) != 1) begin
            p_err = 1'b1;
        end else if (m_run == STABLE) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (a[i]) k = i;
            v = decode_ref(s);
            if (v >= 0) begin
                p_hex[4*k +: 4] = v[3:0];
                p_dv[k] = 1'b1;
                m_seen = m_seen | a;
                if (m_seen == 4'hF) begin
                    p_frame = 1'b1;
                    m_seen = 4'h0;
                end
            end else begin
                p_dv[k] = 1'b0;
                p_err = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        reset = 1'b0;
        an = a;
        seg = s;
        @(posedge clk);
        #1;
        e_hex = p_hex;
        e_dv = p_dv;
        e_frame = p_frame;
        e_err = p_err;
        model_sample(a, s);
    endtask

    task automatic rst_step(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        reset = 1'b1;
        an = a;
        seg = s;
        @(posedge clk);
        #1;
        e_hex = '0; e_dv = '0; e_frame = 1'b0; e_err = 1'b0;
        p_hex = '0; p_dv = '0; p_frame = 1'b0; p_err = 1'b0;
        m_seen = '0; m_have_prev = 0; m_run = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst_step(4'($urandom()), 7'($urandom()));
            total++;
            if ({hex_out, digit_valid, frame_valid, err} !== 22'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got hex=%h dv=%b fv=%b err=%b want all 0", i, hex_out, digit_valid, frame_valid, err);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(4'h0, 7'($urandom()));
            total++;
            if ({hex_out, digit_valid, frame_valid, err} !== 22'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got hex=%h dv=%b fv=%b err=%b want all 0", i, hex_out, digit_valid, frame_valid, err);
            end
        end
    endtask

    task automatic test_capture();
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 7'h5B);
            total++;
            if (digit_valid !== 4'b0000 || err !== 1'b0) begin
                bad++;
                $display("FAIL capture_early cyc=%0d got dv=%b err=%b want dv=0000 err=0", i, digit_valid, err);
            end
        end
        step(4'b0001, 7'h5B);
        total++;
        if (hex_out[3:0] !== 4'h2 || digit_valid !== 4'b0001 || err !== 1'b0) begin
            bad++;
            $display("FAIL capture_digit got nib=%h dv=%b err=%b want nib=2 dv=0001 err=0", hex_out[3:0], digit_valid, err);
        end
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 7'h5B);
            total++;
            if (hex_out !== 16'h0002 || digit_valid !== 4'b0001 || err !== 1'b0 || frame_valid !== 1'b0) begin
                bad++;
                $display("FAIL capture_hold cyc=%0d got hex=%h dv=%b err=%b fv=%b want hex=0002 dv=0001 err=0 fv=0", i, hex_out, digit_valid, err, frame_valid);
            end
        end
    endtask

    task automatic test_frame();
        logic [6:0] pats [4];
        int fcount;
        pats = '{7'h06, 7'h77, 7'h7C, 7'h71};
        fcount = 0;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step(4'(1 << d), pats[d]);
                if (frame_valid === 1'b1) fcount++;
                total++;
                if ({hex_out, digit_valid, frame_valid, err} !== {e_hex, e_dv, e_frame, e_err}) begin
                    bad++;
                    $display("FAIL frame_model d=%0d c=%0d got hex=%h dv=%b fv=%b err=%b want hex=%h dv=%b fv=%b err=%b", d, c, hex_out, digit_valid, frame_valid, err, e_hex, e_dv, e_frame, e_err);
                end
            end
        end
        total++;
        if (hex_out !== 16'hFBA1 || digit_valid !== 4'hF || fcount != 1) begin
            bad++;
            $display("FAIL frame_result got hex=%h dv=%b pulses=%0d want hex=FBA1 dv=1111 pulses=1", hex_out, digit_valid, fcount);
        end
    endtask

    task automatic test_glitch();
        logic [6:0] seq [7];
        seq = '{7'h3F, 7'h3F, 7'h3E, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        for (int i = 0; i < 7; i++) begin
            step(4'b0010, seq[i]);
            total++;
            if (i < 6 && (hex_out[7:4] !== 4'hA || err !== 1'b0)) begin
                bad++;
                $display("FAIL glitch_hold cyc=%0d got nib=%h err=%b want nib=A err=0", i, hex_out[7:4], err);
            end else if (i == 6 && (hex_out[7:4] !== 4'h0 || digit_valid[1] !== 1'b1)) begin
                bad++;
                $display("FAIL glitch_capture got nib=%h dv1=%b want nib=0 dv1=1", hex_out[7:4], digit_valid[1]);
            end
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 4; i++) begin
            step(4'b0100, 7'h00);
            total++;
            if (err !== (i == 3) || hex_out[11:8] !== 4'hB || digit_valid[2] !== (i != 3)) begin
                bad++;
                $display("FAIL illegal_seg cyc=%0d got err=%b nib=%h dv2=%b want err=%0d nib=B dv2=%0d", i, err, hex_out[11:8], digit_valid[2], i == 3, i != 3);
            end
        end
        step(4'b1001, 7'h3F);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL illegal_an_pre got err=%b want 0", err);
        end
        step(4'b0000, 7'h00);
        total++;
        if (err !== 1'b1 || digit_valid !== 4'b1011 || hex_out !== 16'hFB01) begin
            bad++;
            $display("FAIL illegal_an got err=%b dv=%b hex=%h want err=1 dv=1011 hex=FB01", err, digit_valid, hex_out);
        end
        step(4'b0000, 7'h00);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL illegal_an_post got err=%b want 0", err);
        end
    endtask

    task automatic test_reset_mid();
        step(4'b1000, 7'h7F);
        step(4'b1000, 7'h7F);
        rst_step(4'b1000, 7'h7F);
        total++;
        if ({hex_out, digit_valid, frame_valid, err} !== 22'd0) begin
            bad++;
            $display("FAIL midreset_clear got hex=%h dv=%b fv=%b err=%b want all 0", hex_out, digit_valid, frame_valid, err);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b1000, 7'h7F);
            total++;
            if (digit_valid !== 4'b0000 || hex_out !== 16'h0000) begin
                bad++;
                $display("FAIL midreset_early cyc=%0d got dv=%b hex=%h want dv=0000 hex=0000", i, digit_valid, hex_out);
            end
        end
        step(4'b1000, 7'h7F);
        total++;
        if (hex_out !== 16'h8000 || digit_valid !== 4'b1000) begin
            bad++;
            $display("FAIL midreset_capture got hex=%h dv=%b want hex=8000 dv=1000", hex_out, digit_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        int dwell;
        for (int n = 0; n < 160; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 4'h0;
                1:       a = 4'($urandom());
                default: a = 4'(1 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 9) < 7) s = seg_tab[$urandom_range(0, 15)];
            else s = 7'($urandom());
            dwell = $urandom_range(1, 6);
            if ($urandom_range(0, 39) == 0) begin
                rst_step(a, s);
                total++;
                if ({hex_out, digit_valid, frame_valid, err} !== 22'd0) begin
                    bad++;
                    $display("FAIL random_reset n=%0d got hex=%h dv=%b fv=%b err=%b want all 0", n, hex_out, digit_valid, frame_valid, err);
                end
            end
            for (int c = 0; c < dwell; c++) begin
                step(a, s);
                total++;
                if ({hex_out, digit_valid, frame_valid, err} !== {e_hex, e_dv, e_frame, e_err} || (err && frame_valid)) begin
                    bad++;
                    $display("FAIL random_model n=%0d c=%0d got hex=%h dv=%b fv=%b err=%b want hex=%h dv=%b fv=%b err=%b", n, c, hex_out, digit_valid, frame_valid, err, e_hex, e_dv, e_frame, e_err);
                end
            end
        end
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        test_reset();
        test_capture();
        test_frame();
        test_glitch();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
